// File: rtl/rks_tape_encoder.sv
// Specialist cassette playback encoder: pilot, sync, data bytes and idle tail, Manchester coded MSB first.
// Define TAPE_CHECKSUM_EN to append a 16-bit byte sum (high then low) after the last data byte.
module rks_tape_encoder #(
    parameter int         HALF_PERIOD = 250,
    parameter int         PILOT_BYTES = 256,
    parameter logic [7:0] SYNC_BYTE   = 8'hE6,
    parameter int         TAIL_HALVES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        start,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        din_last,
    output logic        din_ready,
    output logic        tape_out,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic [15:0] byte_cnt
);

    localparam int HCW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PILOT, S_SYNC, S_DATA, S_TAIL
`ifdef TAPE_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t          r_state, w_state;
    logic [HCW-1:0]  r_half_cnt, w_half_cnt;
    logic            r_half, w_half;
    logic [2:0]      r_bit_idx, w_bit_idx;
    logic [7:0]      r_shift, w_shift;
    logic            r_cur_last, w_cur_last;
    logic [15:0]     r_pilot_cnt, w_pilot_cnt;
    logic [15:0]     r_tail_cnt, w_tail_cnt;
    logic            r_tape, w_tape;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            r_underrun, w_underrun;
    logic [15:0]     r_byte_cnt, w_byte_cnt;
    logic [7:0]      r_hold, w_hold;
    logic            r_hold_full, w_hold_full;
    logic            r_hold_last, w_hold_last;
`ifdef TAPE_CHECKSUM_EN
    logic [15:0]     r_sum, w_sum;
    logic            r_csum_lo, w_csum_lo;
`endif

    logic            w_din_ready, w_load, w_bnd, w_avail, w_avail_last;
    logic [7:0]      w_avail_byte;
    logic            w_byte_end, w_nb_ok;
    logic [7:0]      w_nb;

    assign w_din_ready  = !r_hold_full &&
                          (r_state == S_PILOT || r_state == S_SYNC || r_state == S_DATA);
    assign w_load       = din_valid && w_din_ready;
    assign w_bnd        = ce && (r_half_cnt == HCW'(HALF_PERIOD - 1));
    // A byte arriving on the boundary cycle passes straight through to the shifter.
    assign w_avail      = r_hold_full || w_load;
    assign w_avail_byte = r_hold_full ? r_hold : din;
    assign w_avail_last = r_hold_full ? r_hold_last : din_last;

    always_comb begin
        w_state     = r_state;
        w_half_cnt  = r_half_cnt;
        w_half      = r_half;
        w_bit_idx   = r_bit_idx;
        w_shift     = r_shift;
        w_cur_last  = r_cur_last;
        w_pilot_cnt = r_pilot_cnt;
        w_tail_cnt  = r_tail_cnt;
        w_tape      = r_tape;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_underrun  = r_underrun;
        w_byte_cnt  = r_byte_cnt;
        w_hold      = r_hold;
        w_hold_full = r_hold_full;
        w_hold_last = r_hold_last;
`ifdef TAPE_CHECKSUM_EN
        w_sum       = r_sum;
        w_csum_lo   = r_csum_lo;
`endif
        w_byte_end  = 1'b0;
        w_nb_ok     = 1'b0;
        w_nb        = '0;

        if (w_load) begin
            w_hold      = din;
            w_hold_last = din_last;
            w_hold_full = 1'b1;
        end

        if (r_state != S_IDLE && ce)
            w_half_cnt = w_bnd ? '0 : r_half_cnt + 1'b1;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state     = S_PILOT;
                    w_busy      = 1'b1;
                    w_underrun  = 1'b0;
                    w_byte_cnt  = '0;
                    w_pilot_cnt = '0;
                    w_half_cnt  = '0;
                    w_half      = 1'b0;
                    w_bit_idx   = '0;
                    w_shift     = '0;
                    w_cur_last  = 1'b0;
                    w_tape      = 1'b0;
                    w_hold_full = 1'b0;
`ifdef TAPE_CHECKSUM_EN
                    w_sum       = '0;
                    w_csum_lo   = 1'b0;
`endif
                end
            end
            S_TAIL: begin
                if (w_bnd) begin
                    if (r_tail_cnt == 16'(TAIL_HALVES - 1)) begin
                        w_state    = S_IDLE;
                        w_busy     = 1'b0;
                        w_done     = 1'b1;
                        w_tail_cnt = '0;
                    end else begin
                        w_tail_cnt = r_tail_cnt + 16'd1;
                    end
                end
            end
            default: begin
                if (w_bnd) begin
                    if (!r_half) begin
                        w_half = 1'b1;
                        w_tape = ~r_shift[7];
                    end else if (r_bit_idx != 3'd7) begin
                        w_half    = 1'b0;
                        w_bit_idx = r_bit_idx + 3'd1;
                        w_shift   = {r_shift[6:0], 1'b0};
                        w_tape    = r_shift[6];
                    end else begin
                        w_byte_end = 1'b1;
                    end
                end
            end
        endcase

        if (w_byte_end) begin
            case (r_state)
                S_PILOT: begin
                    w_nb_ok = 1'b1;
                    if (r_pilot_cnt == 16'(PILOT_BYTES - 1)) begin
                        w_state = S_SYNC;
                        w_nb    = SYNC_BYTE;
                    end else begin
                        w_pilot_cnt = r_pilot_cnt + 16'd1;
                    end
                end
                S_SYNC, S_DATA: begin
                    if (r_state == S_DATA && r_cur_last) begin
`ifdef TAPE_CHECKSUM_EN
                        w_state   = S_CSUM;
                        w_nb      = r_sum[15:8];
                        w_csum_lo = 1'b0;
                        w_nb_ok   = 1'b1;
`endif
                    end else if (w_avail) begin
                        w_state     = S_DATA;
                        w_nb        = w_avail_byte;
                        w_cur_last  = w_avail_last;
                        w_hold_full = 1'b0;
                        w_byte_cnt  = r_byte_cnt + 16'd1;
                        w_nb_ok     = 1'b1;
`ifdef TAPE_CHECKSUM_EN
                        w_sum       = r_sum + {8'd0, w_avail_byte};
`endif
                    end else begin
                        w_underrun = 1'b1;
                    end
                end
`ifdef TAPE_CHECKSUM_EN
                S_CSUM: begin
                    if (!r_csum_lo) begin
                        w_nb      = r_sum[7:0];
                        w_csum_lo = 1'b1;
                        w_nb_ok   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase

            if (w_nb_ok) begin
                w_half    = 1'b0;
                w_bit_idx = '0;
                w_shift   = w_nb;
                w_tape    = w_nb[7];
            end else begin
                w_state    = S_TAIL;
                w_tape     = 1'b0;
                w_tail_cnt = '0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_half_cnt  <= '0;
            r_half      <= 1'b0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_cur_last  <= 1'b0;
            r_pilot_cnt <= '0;
            r_tail_cnt  <= '0;
            r_tape      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
            r_byte_cnt  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
`ifdef TAPE_CHECKSUM_EN
            r_sum       <= '0;
            r_csum_lo   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_half_cnt  <= w_half_cnt;
            r_half      <= w_half;
            r_bit_idx   <= w_bit_idx;
            r_shift     <= w_shift;
            r_cur_last  <= w_cur_last;
            r_pilot_cnt <= w_pilot_cnt;
            r_tail_cnt  <= w_tail_cnt;
            r_tape      <= w_tape;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_underrun  <= w_underrun;
            r_byte_cnt  <= w_byte_cnt;
            r_hold      <= w_hold;
            r_hold_full <= w_hold_full;
            r_hold_last <= w_hold_last;
`ifdef TAPE_CHECKSUM_EN
            r_sum       <= w_sum;
            r_csum_lo   <= w_csum_lo;
`endif
        end
    end

    assign din_ready = w_din_ready;
    assign tape_out  = r_tape;
    assign busy      = r_busy;
    assign done      = r_done;
    assign underrun  = r_underrun;
    assign byte_cnt  = r_byte_cnt;

endmodule
